// File: rtl/gameend_pkg.sv
// gameend_pkg: shared types and constants for the BombMan game-over controller.
// Holds the controller state enum, the outcome codes carried on 'which', and
// the coordinate width shared with the end-screen painter and VGA timing block.
package gameend_pkg;

  localparam int COORD_W = 10;

  localparam logic [1:0] WHICH_P1_WIN = 2'd0;
  localparam logic [1:0] WHICH_P2_WIN = 2'd1;
  localparam logic [1:0] WHICH_DRAW   = 2'd2;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    GRACE = 2'd1,
    SLIDE = 2'd2,
    SHOW  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   sig  - level input (already debounced)
//   rise - one-cycle pulse, registered, the cycle after sig is first seen high
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sig_q <= sig;
      rise  <= sig & ~sig_q;
    end
  end

endmodule

// File: rtl/gameend_ctrl.sv
// gameend_ctrl: BombMan game-over controller. Decides the outcome from the two
// death flags, freezes play, slides the result banner in and waits for a
// restart press before pulsing game_reset.
// Build option: GAMEEND_SLIDE_EN - defined: banner slides down SLIDE_STEP
//   pixels per frame; undefined: banner appears at BANNER_Y_FINAL at once.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   frame_tick          - one-cycle pulse per frame
//   p1_dead, p2_dead    - player death levels
//   restart             - debounced restart button level
//   which               - outcome (0 p1 wins, 1 p2 wins, 2 draw)
//   show_end            - end screen active
//   p_x, p_y            - banner offset to the painter
//   freeze              - halts player movement and bomb timers
//   game_reset          - one-cycle game restart pulse
//
// state | meaning
// PLAY  | game running, nobody dead yet
// GRACE | one player dead, survivor may still die inside the draw window
// SLIDE | outcome fixed, banner moving into place, play frozen
// SHOW  | banner in place, waiting for a restart press after the minimum show time
module gameend_ctrl
  import gameend_pkg::*;
#(
  parameter int DRAW_WINDOW_FRAMES = 30,
  parameter int BANNER_X           = 160,
  parameter int BANNER_Y_FINAL     = 120,
`ifdef GAMEEND_SLIDE_EN
  parameter int SLIDE_STEP         = 4,
`endif
  parameter int MIN_SHOW_FRAMES    = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               p1_dead,
  input  logic               p2_dead,
  input  logic               restart,
  output logic [1:0]         which,
  output logic               show_end,
  output logic [COORD_W-1:0] p_x,
  output logic [COORD_W-1:0] p_y,
  output logic               freeze,
  output logic               game_reset
);

  localparam int CNT_MAX = max_int(DRAW_WINDOW_FRAMES, MIN_SHOW_FRAMES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [COORD_W-1:0] Y_FINAL = COORD_W'(BANNER_Y_FINAL);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [1:0]         which_n;
  logic               show_end_n, freeze_n, game_reset_n;
  logic [COORD_W-1:0] p_x_n, p_y_n;
  logic               restart_rise;
  logic               survivor_dead;

  rise_detect u_restart_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (restart),
    .rise (restart_rise)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  // which==P2_WIN means player 1 died first, so player 2 is the survivor.
  assign survivor_dead = (which == WHICH_P2_WIN) ? p2_dead : p1_dead;

`ifdef GAMEEND_SLIDE_EN
  // Sum in one extra bit so the clamp cannot be fooled by wrap-around.
  logic [COORD_W:0]   y_sum;
  logic [COORD_W-1:0] y_step;
  assign y_sum  = {1'b0, p_y} + (COORD_W + 1)'(SLIDE_STEP);
  assign y_step = (y_sum > {1'b0, Y_FINAL}) ? Y_FINAL : y_sum[COORD_W-1:0];
  localparam logic [COORD_W-1:0] Y_ENTRY = '0;
`else
  localparam logic [COORD_W-1:0] Y_ENTRY = Y_FINAL;
`endif

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    which_n      = which;
    show_end_n   = show_end;
    p_x_n        = p_x;
    p_y_n        = p_y;
    freeze_n     = freeze;
    game_reset_n = 1'b0;

    case (state)
      PLAY: begin
        if (p1_dead && p2_dead) begin
          which_n    = WHICH_DRAW;
          state_n    = SLIDE;
          show_end_n = 1'b1;
          freeze_n   = 1'b1;
          p_x_n      = COORD_W'(BANNER_X);
          p_y_n      = Y_ENTRY;
        end else if (p1_dead) begin
          which_n = WHICH_P2_WIN;
          cnt_n   = '0;
          state_n = GRACE;
        end else if (p2_dead) begin
          which_n = WHICH_P1_WIN;
          cnt_n   = '0;
          state_n = GRACE;
        end
      end

      GRACE: begin
        // A survivor death beats an expiring window in the same cycle.
        if (survivor_dead || (frame_tick && cnt_inc == CNT_W'(DRAW_WINDOW_FRAMES))) begin
          if (survivor_dead) which_n = WHICH_DRAW;
          state_n    = SLIDE;
          show_end_n = 1'b1;
          freeze_n   = 1'b1;
          p_x_n      = COORD_W'(BANNER_X);
          p_y_n      = Y_ENTRY;
        end else if (frame_tick) begin
          cnt_n = cnt_inc;
        end
      end

      SLIDE: begin
        if (p_y == Y_FINAL) begin
          cnt_n   = '0;
          state_n = SHOW;
        end
`ifdef GAMEEND_SLIDE_EN
        else if (frame_tick) begin
          p_y_n = y_step;
        end
`endif
      end

      SHOW: begin
        if (restart_rise && cnt == CNT_W'(MIN_SHOW_FRAMES)) begin
          game_reset_n = 1'b1;
          state_n      = PLAY;
          cnt_n        = '0;
          which_n      = WHICH_P1_WIN;
          show_end_n   = 1'b0;
          freeze_n     = 1'b0;
          p_x_n        = '0;
          p_y_n        = '0;
        end else if (frame_tick && cnt != CNT_W'(MIN_SHOW_FRAMES)) begin
          cnt_n = cnt_inc;
        end
      end

      default: state_n = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PLAY;
      cnt        <= '0;
      which      <= WHICH_P1_WIN;
      show_end   <= 1'b0;
      p_x        <= '0;
      p_y        <= '0;
      freeze     <= 1'b0;
      game_reset <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      which      <= which_n;
      show_end   <= show_end_n;
      p_x        <= p_x_n;
      p_y        <= p_y_n;
      freeze     <= freeze_n;
      game_reset <= game_reset_n;
    end
  end

endmodule

// File: doc/gameend_ctrl.md
# gameend_ctrl

Game-over controller for BombMan. Watches both players' death flags, decides the outcome (player 1 wins, player 2 wins, or draw) and freezes gameplay. It then slides the result banner into place and hands winner code and banner offset to the end-screen painter. It sits between the collision/explosion logic and the end-screen painter, and waits for a restart press before issuing a game reset.

## Interface
- DRAW_WINDOW_FRAMES, 30: frames after the first death during which a second death turns the result into a draw
- BANNER_X, 160: horizontal banner offset, in pixels
- BANNER_Y_FINAL, 120: final vertical banner offset, in pixels
- SLIDE_STEP, 4: vertical pixels advanced per frame while sliding
- MIN_SHOW_FRAMES, 120: frames the banner must be fully shown before restart is accepted

Ports:
- clk  in  1  system pixel clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vsync)
- p1_dead  in  1  level; player 1 has been hit
- p2_dead  in  1  level; player 2 has been hit
- restart  in  1  debounced restart button, level
- which  out  2  outcome: 0 = player 1 wins, 1 = player 2 wins, 2 = draw
- show_end  out  1  end screen is active; selects painter output at the display mux
- p_x  out  10  banner horizontal offset to the painter
- p_y  out  10  banner vertical offset to the painter
- freeze  out  1  halts player movement and bomb timers
- game_reset  out  1  one-cycle pulse that restarts the game

## Operation
- States: PLAY, GRACE, SLIDE, SHOW.
- PLAY:
  - Only p1_dead → which=1, frame counter cleared, go to GRACE.
  - Only p2_dead → which=0, go to GRACE.
  - Both in the same cycle → which=2, go straight to SLIDE.
- GRACE:
  - Game keeps running; freeze=0.
  - The surviving player's dead flag going high → which=2, go to SLIDE.
  - On each frame_tick the counter increments. When it reaches DRAW_WINDOW_FRAMES, go to SLIDE; which keeps its latched value.
  - If the survivor's death and the expiring tick land in the same cycle, the death wins and which=2.
- SLIDE:
  - On entry: p_y=0, p_x=BANNER_X, show_end=1, freeze=1.
  - Each frame_tick sets p_y = min(p_y + SLIDE_STEP, BANNER_Y_FINAL). Add in 11 bits, clamp, never overshoot.
  - When p_y equals BANNER_Y_FINAL, clear the frame counter and go to SHOW.
- SHOW:
  - Outputs hold.
  - The counter increments per frame_tick and saturates at MIN_SHOW_FRAMES.
  - A restart rising edge with the counter saturated pulses game_reset for one cycle and returns to PLAY. All outputs return to reset values on that cycle.
- Restart edges before saturation are discarded, not queued. Holding restart through saturation does nothing; the button must be released and pressed again.
- Dead flags are ignored outside PLAY and GRACE. which changes only on the transitions listed above.

## Timing
- Reset values: which=0, show_end=0, p_x=0, p_y=0, freeze=0, game_reset=0; state PLAY, counter 0.
- rst overrides everything on the clock edge, mid-slide included.
- All outputs are registered.
- Death sample to state/which update: 1 cycle.
- SLIDE entry to show_end/freeze high: 1 cycle.
- p_y updates the cycle after frame_tick.
- Restart edge detection takes 1 cycle (registered previous value). game_reset goes high 1 cycle after the press is sampled and lasts exactly 1 cycle.
- Slide length in frames = ceil(BANNER_Y_FINAL / SLIDE_STEP). With defaults: 30 frames.

## Configuration
- GAMEEND_SLIDE_EN defined: banner slides as described above.
- GAMEEND_SLIDE_EN undefined: SLIDE lasts one cycle. p_y is loaded with BANNER_Y_FINAL directly and the state moves to SHOW on the next cycle. SLIDE_STEP is unused.

## Structure
- gameend_pkg holds:
  - state enum (PLAY, GRACE, SLIDE, SHOW)
  - WHICH_P1_WIN=0, WHICH_P2_WIN=1, WHICH_DRAW=2
  - 10-bit coordinate width constant, shared with the painter and the VGA timing block
- Sub-module rise_detect: registered rising-edge detector, used for restart.
- The frame counter stays in gameend_ctrl. It is sized for max(DRAW_WINDOW_FRAMES, MIN_SHOW_FRAMES).

## Test plan
- p1_dead high in PLAY, no p2 death, 30 frame_ticks → which=1; freeze stays 0 until the 30th tick, then freeze=1, show_end=1, p_y=0; after 30 more ticks p_y=120 and state is SHOW.
- p2_dead high, then p1_dead high after 10 ticks → which=2 and SLIDE entered 1 cycle after p1_dead.
- p1_dead and p2_dead high in the same cycle → which=2 with no GRACE period.
- In SHOW, restart pressed after 50 ticks → no game_reset. Release, 70 more ticks, press again → one-cycle game_reset, then all outputs 0.
- rst asserted mid-slide (p_y=60) → next cycle all outputs at reset values, state PLAY.
- GAMEEND_SLIDE_EN undefined: single death plus 30 ticks → p_y=120 on the first SLIDE cycle, SHOW the next cycle.
